// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a BOOT/RUN/HALTED controller,
// branch/jump redirect (branch has priority), stall hold and an IF/ID register.
// Optional feature: define FETCH_MISALIGN_CHK_EN to enable redirect-target
// alignment checking (sticky misalign_err, target bits [1:0] forced to zero).
// Without it, misalign_err stays 0 and targets are loaded unmodified.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_misalign;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_misalign_nxt;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_target_misaligned;
    logic [31:0] w_pc_plus4;

    // Redirect selection: branch wins over jump when both are requested.
    assign w_redirect   = branch_taken | jump;
    assign w_target_raw = branch_taken ? branch_target : jump_target;
    // Wraps naturally modulo 2^32.
    assign w_pc_plus4   = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_target_misaligned = |w_target_raw[1:0];
    assign w_target            = {w_target_raw[31:2], 2'b00};
`else
    assign w_target_misaligned = 1'b0;
    assign w_target            = w_target_raw;
`endif

    // Next-state and next-register computation for the fetch controller.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc4_nxt      = r_pc4;
        w_valid_nxt    = r_valid;
        w_misalign_nxt = r_misalign;
        case (r_state)
            ST_BOOT: begin
                // One settling cycle: PC stays at the reset vector, nothing issued.
                w_state_nxt = ST_RUN;
                w_pc_nxt    = RESET_PC;
                w_valid_nxt = 1'b0;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    // Redirect beats stall; the instruction fetched this cycle is wrong-path.
                    w_pc_nxt       = w_target;
                    w_valid_nxt    = 1'b0;
                    w_misalign_nxt = r_misalign | w_target_misaligned;
                    if (halt && !stall) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (stall) begin
                    w_state_nxt = ST_RUN;
                end else if (halt) begin
                    w_state_nxt = ST_HALTED;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_instr_nxt = instr_in;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                end
            end
            ST_HALTED: begin
                // Terminal until reset: all control inputs are ignored.
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_PC;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0000_0000;
            r_pc4      <= 32'h0000_0000;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc4      <= w_pc4_nxt;
            r_valid    <= w_valid_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign pc_out       = r_pc;
    assign if_id_instr  = r_instr;
    assign if_id_pc4    = r_pc4;
    assign if_id_valid  = r_valid;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected outputs.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;

    logic [31:0] pc_out2;
    logic [31:0] instr_in2;
    logic [31:0] if_id_instr2;
    logic [31:0] if_id_pc42;
    logic        if_id_valid2;
    logic        misalign_err2;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        mis;
        bit          chk_data;
        int          id;
    } exp_t;

    exp_t q_main[$];
    exp_t q_wrap[$];
    int   step_no;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] E_MPC = 32'h0000_0020;
    localparam logic        E_MIS = 1'b1;
`else
    localparam logic [31:0] E_MPC = 32'h0000_0022;
    localparam logic        E_MIS = 1'b0;
`endif

    // Instruction memory model: a distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA5C3_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1357;
    endfunction

    assign instr_in  = mem_word(pc_out);
    assign instr_in2 = mem_word(pc_out2);

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .pc_out(pc_out), .instr_in(instr_in),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .pc_out(pc_out2), .instr_in(instr_in2),
        .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42),
        .if_id_valid(if_id_valid2), .misalign_err(misalign_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, id, obs, exp);
        end
    endtask

    task automatic compare_main();
        exp_t e;
        if (q_main.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", step_no);
        end else begin
            e = q_main.pop_front();
            chk("pc_out", e.id, pc_out, e.pc);
            chk("if_id_valid", e.id, {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("misalign_err", e.id, {31'd0, misalign_err}, {31'd0, e.mis});
            if (e.chk_data) begin
                chk("if_id_instr", e.id, if_id_instr, e.instr);
                chk("if_id_pc4", e.id, if_id_pc4, e.pc4);
            end
        end
    endtask

    task automatic compare_wrap();
        exp_t e;
        if (q_wrap.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL wrap_scoreboard_empty step=%0d observed=0 expected=1", step_no);
        end else begin
            e = q_wrap.pop_front();
            chk("wrap_pc_out", e.id, pc_out2, e.pc);
            chk("wrap_valid", e.id, {31'd0, if_id_valid2}, {31'd0, e.valid});
            chk("wrap_instr", e.id, if_id_instr2, e.instr);
            chk("wrap_pc4", e.id, if_id_pc42, e.pc4);
        end
    endtask

    task automatic push_wrap(input logic [31:0] p, input logic v, input logic [31:0] i, input logic [31:0] p4);
        exp_t e;
        e.pc = p; e.valid = v; e.instr = i; e.pc4 = p4; e.mis = 1'b0; e.chk_data = 1'b1; e.id = step_no + 1;
        q_wrap.push_back(e);
    endtask

    // Drive one cycle of inputs, record expectations, clock, then compare.
    task automatic step(input logic st, input logic h,
                        input logic bt, input logic [31:0] bta,
                        input logic jp, input logic [31:0] jta,
                        input logic [31:0] epc, input logic ev,
                        input logic [31:0] ei, input logic [31:0] ep4,
                        input logic em, input bit cd);
        exp_t e;
        step_no++;
        stall = st; halt = h;
        branch_taken = bt; branch_target = bta;
        jump = jp; jump_target = jta;
        e.pc = epc; e.valid = ev; e.instr = ei; e.pc4 = ep4; e.mis = em; e.chk_data = cd; e.id = step_no;
        q_main.push_back(e);
        @(posedge clk);
        #1;
        compare_main();
    endtask

    initial begin
        checks = 0; failures = 0; step_no = 0;
        rst = 1'b1; stall = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;

        // Reset state.
        #2;
        step_no = 0;
        q_main.push_back('{32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0});
        compare_main();
        chk("wrap_reset_pc", 0, pc_out2, 32'hFFFF_FFF8);

        @(posedge clk);
        #1 rst = 1'b0;

        // Boot cycle, then sequential fetch; wrap instance crosses 2^32.
        push_wrap(32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
        step(0,0, 0,32'h0, 0,32'h0, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        compare_wrap();
        push_wrap(32'hFFFF_FFFC, 1'b1, mem_word(32'hFFFF_FFF8), 32'hFFFF_FFFC);
        step(0,0, 0,32'h0, 0,32'h0, 32'h0000_0004, 1'b1, mem_word(32'h0), 32'h4, 1'b0, 1'b1);
        compare_wrap();
        push_wrap(32'h0000_0000, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0000_0000);
        step(0,0, 0,32'h0, 0,32'h0, 32'h0000_0008, 1'b1, mem_word(32'h4), 32'h8, 1'b0, 1'b1);
        compare_wrap();

        // Stall three cycles at pc=8, then resume.
        for (int k = 0; k < 3; k++) begin
            step(1,0, 0,32'h0, 0,32'h0, 32'h8, 1'b1, mem_word(32'h4), 32'h8, 1'b0, 1'b1);
        end
        step(0,0, 0,32'h0, 0,32'h0, 32'hC, 1'b1, mem_word(32'h8), 32'hC, 1'b0, 1'b1);

        // Branch and jump together under stall: branch wins, squash.
        step(1,0, 1,32'h40, 1,32'h80, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(0,0, 0,32'h0, 0,32'h0, 32'h44, 1'b1, mem_word(32'h40), 32'h44, 1'b0, 1'b1);

        // Jump alone.
        step(0,0, 0,32'h0, 1,32'h100, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(0,0, 0,32'h0, 0,32'h0, 32'h104, 1'b1, mem_word(32'h100), 32'h104, 1'b0, 1'b1);

        // Misaligned jump target.
        step(0,0, 0,32'h0, 1,32'h22, E_MPC, 1'b0, 32'h0, 32'h0, E_MIS, 1'b0);
        step(0,0, 0,32'h0, 0,32'h0, E_MPC + 32'd4, 1'b1, mem_word(E_MPC), E_MPC + 32'd4, E_MIS, 1'b1);

        // Halt while stalled is ignored.
        step(1,1, 0,32'h0, 0,32'h0, E_MPC + 32'd4, 1'b1, mem_word(E_MPC), E_MPC + 32'd4, E_MIS, 1'b1);

        // Halt with jump: redirect applied and HALTED entered.
        step(0,1, 0,32'h0, 1,32'h20, 32'h20, 1'b0, mem_word(E_MPC), E_MPC + 32'd4, E_MIS, 1'b1);

        // Ten HALTED cycles with redirect/stall/halt activity ignored.
        for (int k = 0; k < 10; k++) begin
            step(k[0], k[1], 1'b1, 32'h300, k[2], 32'h500,
                 32'h20, 1'b0, mem_word(E_MPC), E_MPC + 32'd4, E_MIS, 1'b1);
        end

        // Mid-cycle reset takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        step_no++;
        q_main.push_back('{32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, step_no});
        compare_main();
        stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(0,0, 0,32'h0, 0,32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(0,0, 0,32'h0, 0,32'h0, 32'h4, 1'b1, mem_word(32'h0), 32'h4, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
